ysyx_2022040010_div_issue: RTL and testbench
============================================

// Module: ysyx_2022040010_div_issue
// PURPOSE
//  EX-stage initiator for the multicycle divider (start/annul/ready handshake). Takes a decoded
//  DIV/DIVU/REM/REMU(+W) from EX, prepares operands, resolves x/0 and signed overflow locally,
//  drives and stalls on the divider until ready, then returns a one-cycle result to EX/MEM.
// PARAMETERS
//  MAX_CYCLES  80  BUSY-cycle watchdog limit; on expiry the request is annulled and err_o pulses
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   asynchronous, active-low reset
//  ex_req_i      in   1   valid div/rem instruction present in EX
//  ex_signed_i   in   1   1 = DIV/REM(W), 0 = DIVU/REMU(W)
//  ex_word_i     in   1   1 = *W op (32-bit result, sign-extended)
//  ex_rem_i      in   1   1 = remainder, 0 = quotient
//  ex_op1_i      in   64  dividend (rs1)
//  ex_op2_i      in   64  divisor (rs2)
//  flush_i       in   1   pipeline kill of the EX instruction
//  stall_o       out  1   hold IF..EX this cycle
//  res_valid_o   out  1   res_o valid this cycle (one-cycle pulse)
//  res_o         out  64  final rd value
//  err_o         out  1   watchdog expiry pulse
//  div_start_o   out  1   divider start (held high while BUSY)
//  div_annul_o   out  1   divider annul (one-cycle pulse)
//  div_signed_o  out  1   registered ex_signed_i
//  div_32_o      out  1   registered ex_word_i
//  div_op1_o     out  64  registered prepared dividend
//  div_op2_o     out  64  registered prepared divisor
//  div_res_sel_o out  2   2'b10 quotient, 2'b01 remainder; 2'b00 when idle
//  div_ready_i   in   1   divider result ready
//  div_res_i     in   64  divider result (already selected/extended by divider)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output and register 0; watchdog counter 0.
//  Operand prep (comb., from EX inputs): word&signed -> sign-extend bits[31:0]; word&unsigned ->
//   zero-extend bits[31:0]; else pass 64 bits. Special cases use prepared operands:
//   ZERO: op2==0 -> quotient all ones; remainder = op1 (word: sext(op1[31:0])).
//   OVF : signed & op2==-1 & op1==most negative (64b 0x8000..0; word 0xFFFFFFFF_80000000)
//         -> quotient = op1, remainder = 0.
//  States IDLE, BUSY, ABORT, DONE, FAST:
//   IDLE : if ex_req_i & !flush_i: stall_o=1 comb.; special -> latch result, go FAST;
//          else latch prepared ops/signed/word/sel, clear counter, go BUSY. Otherwise stay.
//   BUSY : div_start_o=1, stall_o=1, counter+1. Priority: flush_i -> ABORT; else div_ready_i ->
//          latch div_res_i, go DONE; else counter==MAX_CYCLES-1 -> ABORT with err_o=1 next cycle.
//   ABORT: div_start_o=0, div_annul_o=1, stall_o=0, res_valid_o=0; -> IDLE (1 cycle).
//   DONE : div_start_o=0 (divider returns free), stall_o=0, res_valid_o=!flush_i; -> IDLE.
//   FAST : stall_o=0, res_valid_o=!flush_i, divider untouched; -> IDLE.
//  Latency: ready seen in cycle N of BUSY -> res_valid_o in cycle N+1; special case -> 2 cycles
//   after the request (IDLE then FAST). DONE/ABORT guarantee >=1 start-low cycle between issues.
//  div_op*/sel hold stable across BUSY; sel cleared to 0 in IDLE. Back-to-back requests are
//   re-evaluated in IDLE the cycle after DONE/FAST. Flush in IDLE issues nothing.
//  err_o pulses 1 cycle on watchdog ABORT only; watchdog-aborted instruction gets no result.
// TESTING
//  DIV -7/2 (signed, 64b): start held until ready -> res_o=0xFFFF_FFFF_FFFF_FFFD one pulse,
//   stall_o high from request until DONE, sel=2'b10.
//  REMUW op1=0xFFFFFFFF_00000007, op2=2 -> div_op1_o=0x7, div_32_o=1, res_o=1, sel=2'b01.
//  DIVU 5/0 -> no div_start_o, res_o=0xFFFF_FFFF_FFFF_FFFF in FAST; REM 5/0 -> res_o=5.
//  DIV 0x8000_0000_0000_0000 / -1 -> res_o=0x8000_0000_0000_0000; REM same -> 0; no start.
//  flush_i in 3rd BUSY cycle -> div_annul_o one cycle, start drops, no res_valid_o, then IDLE;
//   following DIVU 100/7 -> 14.
//  div_ready_i never asserted (MAX_CYCLES=80) -> ABORT after 80 BUSY cycles, err_o one pulse;
//   rst low mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_2022040010_div_issue.sv
// EX-stage issue logic for the multicycle divider: operand prep, local x/0 and overflow
// resolution, start/annul/ready handshake with a BUSY watchdog, one-cycle result return.
module ysyx_2022040010_div_issue #(
  parameter int unsigned MAX_CYCLES = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_req_i,
  input  logic        ex_signed_i,
  input  logic        ex_word_i,
  input  logic        ex_rem_i,
  input  logic [63:0] ex_op1_i,
  input  logic [63:0] ex_op2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        res_valid_o,
  output logic [63:0] res_o,
  output logic        err_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic        div_32_o,
  output logic [63:0] div_op1_o,
  output logic [63:0] div_op2_o,
  output logic [1:0]  div_res_sel_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_res_i
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, 63'b0};
  localparam logic [XLEN-1:0] MIN_W = {{33{1'b1}}, 31'b0};

  typedef enum logic [2:0] {IDLE, BUSY, ABORT, DONE, FAST} state_t;

  state_t state, state_n;

  logic [XLEN-1:0] op1_p, op2_p, op1_sx, fast_res;
  logic            is_zero, is_ovf, special;
  logic            latch_ops, latch_fast, latch_div, wdog_abort;
  logic [CW-1:0]   cnt;

  // Operand preparation and special-case result, purely from the EX inputs
  always_comb begin
    op1_sx = {{32{ex_op1_i[31]}}, ex_op1_i[31:0]};
    op1_p  = ex_op1_i;
    op2_p  = ex_op2_i;
    if (ex_word_i) begin
      if (ex_signed_i) begin
        op1_p = op1_sx;
        op2_p = {{32{ex_op2_i[31]}}, ex_op2_i[31:0]};
      end else begin
        op1_p = {32'b0, ex_op1_i[31:0]};
        op2_p = {32'b0, ex_op2_i[31:0]};
      end
    end
    is_zero  = (op2_p == '0);
    is_ovf   = ex_signed_i && (op2_p == '1) && (op1_p == (ex_word_i ? MIN_W : MIN_D));
    special  = is_zero || is_ovf;
    fast_res = '0;
    if (is_zero) begin
      if (ex_rem_i) fast_res = ex_word_i ? op1_sx : op1_p;
      else          fast_res = '1;
    end else if (!ex_rem_i) begin
      fast_res = op1_p;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n     = state;
    stall_o     = 1'b0;
    res_valid_o = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;
    latch_ops   = 1'b0;
    latch_fast  = 1'b0;
    latch_div   = 1'b0;
    wdog_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (ex_req_i && !flush_i) begin
          stall_o = 1'b1;
          if (special) begin
            latch_fast = 1'b1;
            state_n    = FAST;
          end else begin
            latch_ops = 1'b1;
            state_n   = BUSY;
          end
        end
      end
      BUSY: begin
        div_start_o = 1'b1;
        stall_o     = 1'b1;
        if (flush_i) begin
          state_n = ABORT;
        end else if (div_ready_i) begin
          latch_div = 1'b1;
          state_n   = DONE;
        end else if (cnt == CNT_LAST) begin
          wdog_abort = 1'b1;
          state_n    = ABORT;
        end
      end
      ABORT: begin
        div_annul_o = 1'b1;
        state_n     = IDLE;
      end
      DONE, FAST: begin
        res_valid_o = !flush_i;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers: divider operands, select, result, watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      err_o         <= 1'b0;
      res_o         <= '0;
      div_signed_o  <= 1'b0;
      div_32_o      <= 1'b0;
      div_op1_o     <= '0;
      div_op2_o     <= '0;
      div_res_sel_o <= 2'b00;
    end else begin
      err_o <= wdog_abort;
      if (latch_ops)           cnt <= '0;
      else if (state == BUSY)  cnt <= cnt + CW'(1);
      if (latch_fast)          res_o <= fast_res;
      else if (latch_div)      res_o <= div_res_i;
      if (latch_ops) begin
        div_signed_o  <= ex_signed_i;
        div_32_o      <= ex_word_i;
        div_op1_o     <= op1_p;
        div_op2_o     <= op2_p;
        div_res_sel_o <= ex_rem_i ? 2'b01 : 2'b10;
      end else if (state_n != BUSY) begin
        div_res_sel_o <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_div_issue.sv
// Scoreboard bench for the divider issue block with a small fixed-latency divider model.
module tb_ysyx_2022040010_div_issue;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_req_i, ex_signed_i, ex_word_i, ex_rem_i, flush_i;
  logic [63:0] ex_op1_i, ex_op2_i;
  logic        stall_o, res_valid_o, err_o, div_start_o, div_annul_o;
  logic        div_signed_o, div_32_o, div_ready_i;
  logic [63:0] res_o, div_op1_o, div_op2_o, div_res_i;
  logic [1:0]  div_res_sel_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb[$];
  logic ready_en = 1'b1;
  int mcnt;

  ysyx_2022040010_div_issue dut (
    .clk(clk), .rst(rst), .ex_req_i(ex_req_i), .ex_signed_i(ex_signed_i),
    .ex_word_i(ex_word_i), .ex_rem_i(ex_rem_i), .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i),
    .flush_i(flush_i), .stall_o(stall_o), .res_valid_o(res_valid_o), .res_o(res_o),
    .err_o(err_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_32_o(div_32_o), .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o), .div_res_sel_o(div_res_sel_o), .div_ready_i(div_ready_i),
    .div_res_i(div_res_i)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic s, input logic w, input logic [1:0] sel,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] a32, b32;
    logic signed [63:0] a64, b64;
    logic [31:0] r32;
    a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
    if (w) begin
      if (s) r32 = sel[0] ? 32'(a32 % b32) : 32'(a32 / b32);
      else   r32 = sel[0] ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      return {{32{r32[31]}}, r32};
    end
    if (s) return sel[0] ? 64'(a64 % b64) : 64'(a64 / b64);
    return sel[0] ? (a % b) : (a / b);
  endfunction

  // Divider model: ready pulses after LAT+1 start-high cycles
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= 0; div_ready_i <= 1'b0; div_res_i <= '0;
    end else if (!div_start_o) begin
      mcnt <= 0; div_ready_i <= 1'b0;
    end else begin
      mcnt <= mcnt + 1;
      if (ready_en && !div_ready_i && mcnt == LAT - 1) begin
        div_ready_i <= 1'b1;
        div_res_i   <= ref_div(div_signed_o, div_32_o, div_res_sel_o, div_op1_o, div_op2_o);
      end else begin
        div_ready_i <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected value
  always @(negedge clk) begin
    if (rst && res_valid_o) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_res: got %h expected no result", res_o);
      end else begin
        check("res", res_o, sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      ex_req_i = 1'b0; flush_i = 1'b0;
    end
  endtask

  task automatic run_op(input string nm, input logic s, input logic w, input logic r,
                        input logic [63:0] a, input logic [63:0] b, input int flush_at,
                        output int cyc, output int starts, output logic [1:0] sel_seen,
                        output logic [63:0] op1_seen, output logic d32_seen,
                        output logic annul_end, output logic err_end);
    logic fin;
    @(posedge clk); #2;
    ex_req_i = 1'b1; ex_signed_i = s; ex_word_i = w; ex_rem_i = r;
    ex_op1_i = a; ex_op2_i = b; flush_i = 1'b0;
    cyc = 0; starts = 0; sel_seen = 2'b00; op1_seen = '0; d32_seen = 1'b0;
    annul_end = 1'b0; err_end = 1'b0; fin = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (div_start_o) begin
        starts++;
        if (starts == 1) begin
          sel_seen = div_res_sel_o; op1_seen = div_op1_o; d32_seen = div_32_o;
        end
        if (flush_at != 0 && starts == flush_at) flush_i = 1'b1;
      end
      if (!stall_o) begin
        annul_end = div_annul_o; err_end = err_o; fin = 1'b1;
        break;
      end
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_%s: got stall held %0d cycles expected release", nm, cyc);
    end
  endtask

  int cyc, starts;
  logic [1:0] sel;
  logic [63:0] op1s;
  logic d32, an, er;

  initial begin
    rst = 1'b0; ex_req_i = 1'b0; ex_signed_i = 1'b0; ex_word_i = 1'b0; ex_rem_i = 1'b0;
    ex_op1_i = '0; ex_op2_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({stall_o, res_valid_o, err_o, div_start_o, div_annul_o, div_res_sel_o}), 64'd0);
    check("reset_res", res_o, 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    sb.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div", 1, 0, 0, -64'sd7, 64'd2, 0, cyc, starts, sel, op1s, d32, an, er);
    check("div_starts", 64'(starts), 64'(LAT + 1));
    check("div_cycles", 64'(cyc), 64'(LAT + 3));
    check("div_sel", 64'(sel), 64'd2);

    sb.push_back(64'd1);
    run_op("remuw", 0, 1, 1, 64'hFFFF_FFFF_0000_0007, 64'd2, 0, cyc, starts, sel, op1s, d32, an, er);
    check("remuw_op1", op1s, 64'd7);
    check("remuw_d32", 64'(d32), 64'd1);
    check("remuw_sel", 64'(sel), 64'd1);

    sb.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divw", 1, 1, 0, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, cyc, starts, sel, op1s, d32, an, er);
    check("divw_op1_sext", op1s, 64'hFFFF_FFFF_FFFF_FFF9);
    idle(1);
    @(negedge clk);
    check("idle_sel", 64'(div_res_sel_o), 64'd0);

    sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu0", 0, 0, 0, 64'd5, 64'd0, 0, cyc, starts, sel, op1s, d32, an, er);
    check("divu0_starts", 64'(starts), 64'd0);
    check("divu0_cycles", 64'(cyc), 64'd2);

    sb.push_back(64'd5);
    run_op("rem0", 1, 0, 1, 64'd5, 64'd0, 0, cyc, starts, sel, op1s, d32, an, er);
    sb.push_back(64'hFFFF_FFFF_8000_0000);
    run_op("remuw0", 0, 1, 1, 64'h0000_0001_8000_0000, 64'h0000_0005_0000_0000, 0,
           cyc, starts, sel, op1s, d32, an, er);
    check("remuw0_starts", 64'(starts), 64'd0);

    sb.push_back(64'h8000_0000_0000_0000);
    run_op("ovf_div", 1, 0, 0, 64'h8000_0000_0000_0000, '1, 0, cyc, starts, sel, op1s, d32, an, er);
    check("ovf_starts", 64'(starts), 64'd0);
    sb.push_back(64'd0);
    run_op("ovf_rem", 1, 0, 1, 64'h8000_0000_0000_0000, '1, 0, cyc, starts, sel, op1s, d32, an, er);
    sb.push_back(64'hFFFF_FFFF_8000_0000);
    run_op("ovf_divw", 1, 1, 0, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 0,
           cyc, starts, sel, op1s, d32, an, er);
    check("ovfw_starts", 64'(starts), 64'd0);

    run_op("flush", 1, 0, 0, 64'd100, 64'd7, 3, cyc, starts, sel, op1s, d32, an, er);
    check("flush_starts", 64'(starts), 64'd3);
    check("flush_annul", 64'(an), 64'd1);
    check("flush_err", 64'(er), 64'd0);
    idle(1);
    @(negedge clk);
    check("flush_annul_drop", 64'({div_annul_o, div_start_o}), 64'd0);

    sb.push_back(64'd14);
    run_op("divu", 0, 0, 0, 64'd100, 64'd7, 0, cyc, starts, sel, op1s, d32, an, er);

    ready_en = 1'b0;
    run_op("wdog", 0, 0, 0, 64'd9, 64'd3, 0, cyc, starts, sel, op1s, d32, an, er);
    check("wdog_starts", 64'(starts), 64'd80);
    check("wdog_err", 64'(er), 64'd1);
    check("wdog_annul", 64'(an), 64'd1);
    idle(1);
    @(negedge clk);
    check("wdog_err_drop", 64'(err_o), 64'd0);
    ready_en = 1'b1;

    @(posedge clk); #2;
    ex_req_i = 1'b1; ex_signed_i = 1'b0; ex_word_i = 1'b0; ex_rem_i = 1'b0;
    ex_op1_i = 64'd100; ex_op2_i = 64'd7;
    repeat (3) @(negedge clk);
    #1 ex_req_i = 1'b0; rst = 1'b0;
    #1;
    check("rst_busy_ctrl", 64'({stall_o, res_valid_o, err_o, div_start_o, div_annul_o, div_res_sel_o}), 64'd0);
    check("rst_busy_res", res_o, 64'd0);
    check("rst_busy_op1", div_op1_o, 64'd0);
    @(posedge clk); #2 rst = 1'b1;

    sb.push_back(64'd3);
    run_op("recover", 0, 0, 0, 64'd9, 64'd3, 0, cyc, starts, sel, op1s, d32, an, er);
    idle(3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
